dmem_resp_ctrl: RTL and testbench

- Memory-side responder for the data-cache miss/write-back path.
- Accepts one word request at a time from the cache controller over a valid/ready handshake and models main-memory access latency with a countdown.
- Performs byte-enabled writes and returns read data with a valid/ready response handshake.
- Replaces the zero-latency data memory so the cache sees realistic stalls.

---
 rtl/dmem_pkg.sv | 25 ++
 rtl/dmem_array.sv | 34 +++
 rtl/dmem_resp_ctrl.sv | 156 +++++++++++++++
 tb/tb_dmem_resp_ctrl.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder: FSM encoding and byte merge.
package dmem_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned BE_W   = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_e;

  // Bytes with be=0 keep the old value.
  function automatic logic [WORD_W-1:0] be_merge(input logic [WORD_W-1:0] old_w,
                                                 input logic [WORD_W-1:0] new_w,
                                                 input logic [BE_W-1:0]   be);
    logic [WORD_W-1:0] r;
    r = old_w;
    for (int i = 0; i < BE_W; i++) begin
      if (be[i]) r[8*i +: 8] = new_w[8*i +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Synchronous single-port word RAM with byte-enable write; the read port returns the
// post-merge word on a write so the responder can echo it back.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  localparam int unsigned IdxW = $clog2(DEPTH_WORDS)
) (
  input  logic              clk_i,
  input  logic              en_i,
  input  logic              we_i,
  input  logic [IdxW-1:0]   idx_i,
  input  logic [WORD_W-1:0] wdata_i,
  input  logic [BE_W-1:0]   be_i,
  output logic [WORD_W-1:0] rdata_o
);

  logic [WORD_W-1:0] mem [DEPTH_WORDS];
  logic [WORD_W-1:0] rdata_q;
  logic [WORD_W-1:0] merged;

  assign merged = be_merge(mem[idx_i], wdata_i, be_i);

  // Contents are deliberately not reset.
  always_ff @(posedge clk_i) begin
    if (en_i) begin
      if (we_i) mem[idx_i] <= merged;
      rdata_q <= we_i ? merged : mem[idx_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_resp_ctrl.sv
// Memory-side responder with modelled access latency for the D-cache miss/write-back path.
// Define DMEM_RD_FWD_EN to let reads of the last written word bypass the latency countdown.
module dmem_resp_ctrl
  import dmem_pkg::*;
#(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 4
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_wen_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [DATA_W-1:0] req_wdata_i,
  input  logic [BE_W-1:0]   req_be_i,
  output logic              resp_valid_o,
  input  logic              resp_ready_i,
  output logic [DATA_W-1:0] resp_rdata_o,
  output logic              busy_o
);

  localparam int unsigned IdxW    = $clog2(DEPTH_WORDS);
  localparam logic [3:0]  LoadCnt = 4'(LATENCY - 1);

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              wen_q;
  logic [IdxW-1:0]   idx_q;
  logic [DATA_W-1:0] wdata_q;
  logic [BE_W-1:0]   be_q;

  logic [IdxW-1:0]   req_idx;
  logic              accept;
  logic              fwd_hit;
  logic              direct;

  logic              ram_en;
  logic              ram_we;
  logic [IdxW-1:0]   ram_idx;
  logic [DATA_W-1:0] ram_wdata;
  logic [BE_W-1:0]   ram_be;
  logic [DATA_W-1:0] ram_rdata;

  // Low address bits and bits beyond the array depth do not select a word.
  logic unused_addr;
  assign unused_addr = ^{req_addr_i[1:0], req_addr_i[ADDR_W-1:IdxW+2]};

  assign req_idx = req_addr_i[IdxW+1:2];
  assign accept  = req_valid_i && (state_q == S_IDLE);

`ifdef DMEM_RD_FWD_EN
  logic            fwd_valid_q;
  logic [IdxW-1:0] fwd_idx_q;

  // A hit reads the array on the acceptance edge; the stored word is the last commit.
  assign fwd_hit = fwd_valid_q && !req_wen_i && (req_idx == fwd_idx_q);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      fwd_valid_q <= 1'b0;
      fwd_idx_q   <= '0;
    end else if (ram_en && ram_we) begin
      fwd_valid_q <= 1'b1;
      fwd_idx_q   <= ram_idx;
    end
  end
`else
  assign fwd_hit = 1'b0;
`endif

  assign direct = (LATENCY == 1) || fwd_hit;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ram_en    = 1'b0;
    ram_we    = wen_q;
    ram_idx   = idx_q;
    ram_wdata = wdata_q;
    ram_be    = be_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          cnt_d = LoadCnt;
          if (direct) begin
            // Access happens on the acceptance edge, so use the live request fields.
            ram_en    = 1'b1;
            ram_we    = req_wen_i;
            ram_idx   = req_idx;
            ram_wdata = req_wdata_i;
            ram_be    = req_be_i;
            state_d   = S_RESP;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          ram_en  = 1'b1;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (resp_ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wen_q   <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      be_q    <= '0;
    end else if (accept) begin
      wen_q   <= req_wen_i;
      idx_q   <= req_idx;
      wdata_q <= req_wdata_i;
      be_q    <= req_be_i;
    end
  end

  dmem_array #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_array (
    .clk_i  (clk_i),
    .en_i   (ram_en),
    .we_i   (ram_we),
    .idx_i  (ram_idx),
    .wdata_i(ram_wdata),
    .be_i   (ram_be),
    .rdata_o(ram_rdata)
  );

  assign req_ready_o  = (state_q == S_IDLE);
  assign resp_valid_o = (state_q == S_RESP);
  assign resp_rdata_o = (state_q == S_RESP) ? ram_rdata : '0;
  assign busy_o       = (state_q != S_IDLE);

endmodule

// File: tb/tb_dmem_resp_ctrl.sv
// Directed bench for dmem_resp_ctrl: latency, byte merge, backpressure, wrap, reset abort.
module tb_dmem_resp_ctrl;

`ifdef DMEM_RD_FWD_EN
  localparam int FwdLat = 1;
`else
  localparam int FwdLat = 4;
`endif

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_wen_i;
  logic [31:0] req_addr_i;
  logic [31:0] req_wdata_i;
  logic [3:0]  req_be_i;
  logic        resp_valid_o;
  logic        resp_ready_i;
  logic [31:0] resp_rdata_o;
  logic        busy_o;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk_i = ~clk_i;

  dmem_resp_ctrl #(
    .DATA_W     (32),
    .ADDR_W     (32),
    .DEPTH_WORDS(1024),
    .LATENCY    (4)
  ) dut (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_wen_i   (req_wen_i),
    .req_addr_i  (req_addr_i),
    .req_wdata_i (req_wdata_i),
    .req_be_i    (req_be_i),
    .resp_valid_o(resp_valid_o),
    .resp_ready_i(resp_ready_i),
    .resp_rdata_o(resp_rdata_o),
    .busy_o      (busy_o)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_req_ready"}, {31'd0, req_ready_o}, 32'd1);
    check_eq({tag, "_resp_valid"}, {31'd0, resp_valid_o}, 32'd0);
    check_eq({tag, "_resp_rdata"}, resp_rdata_o, 32'd0);
    check_eq({tag, "_busy"}, {31'd0, busy_o}, 32'd0);
  endtask

  // Issue one request just after a clock edge; hold resp_ready low for `hold` RESP cycles.
  task automatic do_txn(input string tag, input logic wen, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be,
                        input logic [31:0] exp_data, input int exp_lat, input int hold);
    int n;
    check_eq({tag, "_ready_before"}, {31'd0, req_ready_o}, 32'd1);
    resp_ready_i = (hold == 0);
    req_valid_i  = 1'b1;
    req_wen_i    = wen;
    req_addr_i   = addr;
    req_wdata_i  = wdata;
    req_be_i     = be;
    @(posedge clk_i);
    #1;
    req_valid_i = 1'b0;
    req_wdata_i = 32'hxxxx_xxxx;
    check_eq({tag, "_busy"}, {31'd0, busy_o}, 32'd1);
    n = 1;
    while (!resp_valid_o && n < 20) begin
      @(posedge clk_i);
      #1;
      n++;
    end
    check_eq({tag, "_latency"}, n, exp_lat);
    check_eq({tag, "_rdata"}, resp_rdata_o, exp_data);
    for (int i = 1; i < hold; i++) begin
      @(posedge clk_i);
      #1;
      check_eq({tag, "_hold_valid"}, {31'd0, resp_valid_o}, 32'd1);
      check_eq({tag, "_hold_rdata"}, resp_rdata_o, exp_data);
      check_eq({tag, "_hold_req_ready"}, {31'd0, req_ready_o}, 32'd0);
    end
    resp_ready_i = 1'b1;
    @(posedge clk_i);
    #1;
    check_eq({tag, "_after_valid"}, {31'd0, resp_valid_o}, 32'd0);
    check_eq({tag, "_after_req_ready"}, {31'd0, req_ready_o}, 32'd1);
  endtask

  // Accept a request, then pulse reset two cycles later, before the commit edge.
  task automatic abort_txn(input string tag, input logic wen, input logic [31:0] addr,
                           input logic [31:0] wdata);
    int rises;
    resp_ready_i = 1'b1;
    req_valid_i  = 1'b1;
    req_wen_i    = wen;
    req_addr_i   = addr;
    req_wdata_i  = wdata;
    req_be_i     = 4'hF;
    @(posedge clk_i);
    #1;
    req_valid_i = 1'b0;
    repeat (1) @(posedge clk_i);
    #1;
    reset_i = 1'b1;
    #1;
    check_idle_outputs(tag);
    @(posedge clk_i);
    #1;
    reset_i = 1'b0;
    rises = 0;
    repeat (8) begin
      @(posedge clk_i);
      #1;
      if (resp_valid_o) rises++;
    end
    check_eq({tag, "_no_resp"}, rises, 0);
    check_idle_outputs({tag, "_post"});
  endtask

  initial begin
    reset_i      = 1'b1;
    req_valid_i  = 1'b0;
    req_wen_i    = 1'b0;
    req_addr_i   = '0;
    req_wdata_i  = '0;
    req_be_i     = '0;
    resp_ready_i = 1'b1;
    #12;
    check_idle_outputs("reset");
    @(posedge clk_i);
    #1;
    reset_i = 1'b0;
    @(posedge clk_i);
    #1;
    check_idle_outputs("reset_release");

    // Full write then read-back.
    do_txn("wr40", 1'b1, 32'h40, 32'hDEADBEEF, 4'hF, 32'hDEADBEEF, 4, 0);
    do_txn("rd40", 1'b0, 32'h40, 32'h0, 4'h0, 32'hDEADBEEF, 4, 0);

    // Partial write merges bytes 0 and 2 only.
    do_txn("wr08", 1'b1, 32'h8, 32'h11223344, 4'hF, 32'h11223344, 4, 0);
    do_txn("wr08p", 1'b1, 32'h8, 32'hAABBCCDD, 4'b0101, 32'h11BB33DD, 4, 0);
    do_txn("rd08", 1'b0, 32'h8, 32'h0, 4'h0, 32'h11BB33DD, 4, 0);

    // Zero byte enables leave the word untouched but still respond.
    do_txn("wr08z", 1'b1, 32'h8, 32'hFFFFFFFF, 4'h0, 32'h11BB33DD, 4, 0);
    do_txn("rd08z", 1'b0, 32'hB, 32'h0, 4'h0, 32'h11BB33DD, 4, 0);

    // Backpressure: resp_ready low for three RESP cycles.
    do_txn("bp", 1'b0, 32'h40, 32'h0, 4'h0, 32'hDEADBEEF, 4, 3);

    // Address wrap modulo 1024 words.
    do_txn("wrap_wr", 1'b1, 32'h1004, 32'h5, 4'hF, 32'h5, 4, 0);
    do_txn("wrap_rd", 1'b0, 32'h0004, 32'h0, 4'h0, 32'h5, 4, 0);

    // Reset mid-WAIT on a read, then normal service.
    abort_txn("abort_rd", 1'b0, 32'h40, 32'h0);
    do_txn("rd40_after", 1'b0, 32'h40, 32'h0, 4'h0, 32'hDEADBEEF, 4, 0);

    // Reset mid-WAIT on a write drops it.
    do_txn("wr80", 1'b1, 32'h80, 32'hCAFE0000, 4'hF, 32'hCAFE0000, 4, 0);
    abort_txn("abort_wr", 1'b1, 32'h80, 32'h11111111);
    do_txn("rd80", 1'b0, 32'h80, 32'h0, 4'h0, 32'hCAFE0000, 4, 0);

    // Read of the last written word; short latency only with forwarding built in.
    do_txn("wr24", 1'b1, 32'h24, 32'h0A0A0A0A, 4'hF, 32'h0A0A0A0A, 4, 0);
    do_txn("wr20", 1'b1, 32'h20, 32'h12345678, 4'hF, 32'h12345678, 4, 0);
    do_txn("fwd20", 1'b0, 32'h20, 32'h0, 4'h0, 32'h12345678, FwdLat, 0);
    do_txn("fwd22", 1'b0, 32'h22, 32'h0, 4'h0, 32'h12345678, FwdLat, 0);
    do_txn("rd24", 1'b0, 32'h24, 32'h0, 4'h0, 32'h0A0A0A0A, 4, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
